// File: rtl/field_splitter_pipe.sv
// -----------------------------------------------------------------------------
// field_splitter_pipe
//
// Registered field splitter. Each accepted word is split into an extended
// immediate, an opcode field and a flag bit. The split fields (not the raw
// word) flow through an output register backed by one skid register, so the
// upstream sees a registered ready and full throughput is kept under
// back-pressure. A counter tracks delivered words.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   flush     - synchronous clear of both buffer entries
//   in_word   - word to split
//   in_sext   - 1: sign-extend immediate, 0: zero-extend (captured per word)
//   in_valid  - in_word/in_sext valid
//   in_ready  - block can accept this cycle (registered, = skid empty)
//   imm_out   - extended immediate
//   op_out    - opcode field
//   flag_out  - flag bit
//   out_valid - output fields valid
//   out_ready - downstream accepts
//   word_cnt  - delivered-word count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module field_splitter_pipe #(
    parameter int DATA_W   = 32,
    parameter int IMM_W    = 16,
    parameter int IMM_LSB  = 0,
    parameter int OP_W     = 8,
    parameter int OP_LSB   = 16,
    parameter int FLAG_BIT = 24,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_word,
    input  logic              in_sext,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] imm_out,
    output logic [OP_W-1:0]   op_out,
    output logic              flag_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  word_cnt
);

    // Parameter sanity checks, evaluated at elaboration.
    if (IMM_W < 1 || IMM_W > DATA_W) begin : g_bad_imm_w
        $error("field_splitter_pipe: IMM_W must be in 1..DATA_W");
    end
    if (IMM_LSB < 0 || IMM_LSB + IMM_W > DATA_W) begin : g_bad_imm_lsb
        $error("field_splitter_pipe: IMM_LSB+IMM_W must not exceed DATA_W");
    end
    if (OP_W < 1 || OP_W > DATA_W) begin : g_bad_op_w
        $error("field_splitter_pipe: OP_W must be in 1..DATA_W");
    end
    if (OP_LSB < 0 || OP_LSB + OP_W > DATA_W) begin : g_bad_op_lsb
        $error("field_splitter_pipe: OP_LSB+OP_W must not exceed DATA_W");
    end
    if (FLAG_BIT < 0 || FLAG_BIT >= DATA_W) begin : g_bad_flag
        $error("field_splitter_pipe: FLAG_BIT must be below DATA_W");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("field_splitter_pipe: CNT_W must be at least 1");
    end

    // ---------------------------------------------------------------- extract
    logic [IMM_W-1:0]  w_imm_field;
    logic [DATA_W-1:0] w_imm_ext;
    logic [OP_W-1:0]   w_op;
    logic              w_flag;
    logic              w_unused;

    assign w_imm_field = in_word[IMM_LSB +: IMM_W];
    assign w_op        = in_word[OP_LSB +: OP_W];
    assign w_flag      = in_word[FLAG_BIT];
    // Bits outside the three fields are intentionally ignored.
    assign w_unused    = ^in_word;

    if (IMM_W == DATA_W) begin : g_no_ext
        assign w_imm_ext = w_imm_field;
    end else begin : g_ext
        assign w_imm_ext = {{(DATA_W-IMM_W){in_sext & w_imm_field[IMM_W-1]}}, w_imm_field};
    end

    // -------------------------------------------------------------- handshake
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_imm;
    logic [OP_W-1:0]   r_out_op;
    logic              r_out_flag;
    logic              r_skid_full;
    logic [DATA_W-1:0] r_skid_imm;
    logic [OP_W-1:0]   r_skid_op;
    logic              r_skid_flag;
    logic [CNT_W-1:0]  r_cnt;

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_out_free;
    logic w_skid_load;

    assign w_in_xfer   = in_valid & ~r_skid_full;
    assign w_out_xfer  = r_out_valid & out_ready;
    // OUT can take a new entry when it is empty or being drained this cycle.
    assign w_out_free  = ~r_out_valid | w_out_xfer;
    assign w_skid_load = ~flush & ~w_out_free & w_in_xfer;

    // ------------------------------------------------------- output / control
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_skid_full <= 1'b0;
            r_out_imm   <= '0;
            r_out_op    <= '0;
            r_out_flag  <= 1'b0;
        end else if (flush) begin
            // Data registers keep stale contents; only the valid state clears.
            r_out_valid <= 1'b0;
            r_skid_full <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_full) begin
                // Oldest word first: the skid entry drains before new input.
                r_out_imm   <= r_skid_imm;
                r_out_op    <= r_skid_op;
                r_out_flag  <= r_skid_flag;
                r_out_valid <= 1'b1;
                r_skid_full <= 1'b0;
            end else if (w_in_xfer) begin
                r_out_imm   <= w_imm_ext;
                r_out_op    <= w_op;
                r_out_flag  <= w_flag;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_xfer) begin
            r_skid_full <= 1'b1;
        end
    end

    // NOTE: the skid payload has no reset; it is only observed once
    // r_skid_full is set, which is itself reset.
    always_ff @(posedge clk) begin
        if (w_skid_load) begin
            r_skid_imm  <= w_imm_ext;
            r_skid_op   <= w_op;
            r_skid_flag <= w_flag;
        end
    end

    // ---------------------------------------------------------------- counter
    // Counts every output transfer, including one coinciding with flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_out_xfer) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign in_ready  = ~r_skid_full;
    assign out_valid = r_out_valid;
    assign imm_out   = r_out_imm;
    assign op_out    = r_out_op;
    assign flag_out  = r_out_flag;
    assign word_cnt  = r_cnt;

endmodule

// File: tb/tb_field_splitter_pipe.sv
// -----------------------------------------------------------------------------
// tb_field_splitter_pipe
//
// Scoreboard bench for field_splitter_pipe. The stimulus process drives
// directed and random traffic; a negedge monitor keeps a queue of expected
// field triples (computed arithmetically from each accepted word) and checks
// handshake signals, output fields and the delivered-word count.
// -----------------------------------------------------------------------------
module tb_field_splitter_pipe;

    localparam int DATA_W   = 32;
    localparam int IMM_W    = 16;
    localparam int IMM_LSB  = 0;
    localparam int OP_W     = 8;
    localparam int OP_LSB   = 16;
    localparam int FLAG_BIT = 24;
    localparam int CNT_W    = 8;

    typedef struct {
        logic [DATA_W-1:0] imm;
        logic [OP_W-1:0]   op;
        logic              flag;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [DATA_W-1:0] in_word;
    logic              in_sext;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] imm_out;
    logic [OP_W-1:0]   op_out;
    logic              flag_out;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  word_cnt;

    int total = 0;
    int bad   = 0;

    exp_t q[$];
    int   exp_cnt = 0;

    field_splitter_pipe #(
        .DATA_W  (DATA_W),
        .IMM_W   (IMM_W),
        .IMM_LSB (IMM_LSB),
        .OP_W    (OP_W),
        .OP_LSB  (OP_LSB),
        .FLAG_BIT(FLAG_BIT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_word  (in_word),
        .in_sext  (in_sext),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .imm_out  (imm_out),
        .op_out   (op_out),
        .flag_out (flag_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .word_cnt (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: field values from plain integer arithmetic.
    function automatic exp_t model(input logic [DATA_W-1:0] w, input logic s);
        exp_t e;
        longint unsigned word, field, ext;
        word  = longint'(w);
        field = (word >> IMM_LSB) % (64'd1 << IMM_W);
        if (s && field >= (64'd1 << (IMM_W - 1)))
            ext = field + (64'd1 << DATA_W) - (64'd1 << IMM_W);
        else
            ext = field;
        e.imm  = ext[DATA_W-1:0];
        field  = (word >> OP_LSB) % (64'd1 << OP_W);
        e.op   = field[OP_W-1:0];
        e.flag = ((word >> FLAG_BIT) % 2) == 1;
        return e;
    endfunction

    // Monitor: inputs change just after posedge, so at negedge everything
    // reflects what the next rising edge will do.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_cnt = 0;
        end else begin
            logic acc, dlv;
            acc = in_valid && (q.size() < 2);
            dlv = (q.size() != 0) && out_ready;
            check("mon_word_cnt", 64'(word_cnt), 64'(exp_cnt));
            check("mon_in_ready", 64'(in_ready), 64'(q.size() < 2));
            check("mon_out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                check("mon_imm", 64'(imm_out), 64'(q[0].imm));
                check("mon_op", 64'(op_out), 64'(q[0].op));
                check("mon_flag", 64'(flag_out), 64'(q[0].flag));
            end
            if (dlv) begin
                void'(q.pop_front());
                exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
            end
            if (flush) q.delete();
            else if (acc) q.push_back(model(in_word, in_sext));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // NOTE: stimulus uses blocking assignments; it runs just after the
        // clock edge so the DUT never sees it change at the edge itself.
        rst_n = 1'b0; flush = 1'b0; in_word = '0; in_sext = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;

        #3;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_in_ready", 64'(in_ready), 1);
        check("rst_imm", 64'(imm_out), 0);
        check("rst_op", 64'(op_out), 0);
        check("rst_flag", 64'(flag_out), 0);
        check("rst_cnt", 64'(word_cnt), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Sign-extended word, one-cycle latency.
        out_ready = 1'b1;
        in_word = 32'h01AB8001; in_sext = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_out_valid", 64'(out_valid), 1);
        check("t1_imm", 64'(imm_out), 64'hFFFF8001);
        check("t1_op", 64'(op_out), 64'hAB);
        check("t1_flag", 64'(flag_out), 1);
        tick();
        check("t1_cnt", 64'(word_cnt), 1);
        check("t1_out_valid_fall", 64'(out_valid), 0);

        // Zero-extension, then positive value with sign extension.
        in_word = 32'h01AB8001; in_sext = 1'b0; in_valid = 1'b1;
        tick();
        in_word = 32'h00CD7FFF; in_sext = 1'b1;
        check("t2_imm_zext", 64'(imm_out), 64'h00008001);
        tick();
        in_valid = 1'b0;
        check("t2_out_valid_hold", 64'(out_valid), 1);
        check("t2_imm_pos", 64'(imm_out), 64'h00007FFF);
        check("t2_op", 64'(op_out), 64'hCD);
        check("t2_flag", 64'(flag_out), 0);
        tick();

        // Back-pressure: two words fill OUT and SKID.
        out_ready = 1'b0;
        in_word = 32'h12348765; in_sext = 1'b1; in_valid = 1'b1;
        tick();
        in_word = 32'h00000042; in_sext = 1'b0;
        tick();
        in_valid = 1'b0;
        check("t3_in_ready_low", 64'(in_ready), 0);
        check("t3_imm_first", 64'(imm_out), 64'hFFFF8765);
        tick();
        check("t3_imm_stable", 64'(imm_out), 64'hFFFF8765);
        out_ready = 1'b1;
        tick();
        check("t3_in_ready_back", 64'(in_ready), 1);
        check("t3_imm_second", 64'(imm_out), 64'h00000042);
        tick();
        check("t3_drained", 64'(out_valid), 0);
        in_word = 32'h7F000001; in_sext = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t3_third_valid", 64'(out_valid), 1);
        check("t3_third_flag", 64'(flag_out), 1);
        tick();
        check("t3_cnt", 64'(word_cnt), 6);

        // Flush with a full buffer and a coincident input.
        out_ready = 1'b0;
        in_word = 32'h11110001; in_sext = 1'b0; in_valid = 1'b1;
        tick();
        in_word = 32'h22220002;
        tick();
        in_word = 32'hDEADBEEF; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("t4_out_valid", 64'(out_valid), 0);
        check("t4_in_ready", 64'(in_ready), 1);
        check("t4_cnt", 64'(word_cnt), 6);
        out_ready = 1'b1;
        tick();
        tick();
        check("t4_nothing_delivered", 64'(out_valid), 0);

        // 300-word stream at full rate from a fresh counter.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_word = $urandom; in_sext = 1'($urandom % 2); in_valid = 1'b1;
            @(negedge clk);
            check("t5_in_ready", 64'(in_ready), 1);
            if (i > 0) check("t5_no_bubble", 64'(out_valid), 1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("t5_cnt_wrap", 64'(word_cnt), 44);
        tick();

        // Random traffic with occasional flush.
        for (int i = 0; i < 600; i++) begin
            in_word   = $urandom;
            in_sext   = 1'($urandom % 2);
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 20) == 0;
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) tick();

        // Asynchronous reset between edges, mid-stream.
        for (int i = 0; i < 5; i++) begin
            in_word = $urandom; in_sext = 1'($urandom % 2); in_valid = 1'b1;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_out_valid", 64'(out_valid), 0);
        check("t6_async_cnt", 64'(word_cnt), 0);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        check("t6_in_ready", 64'(in_ready), 1);
        check("t6_out_valid", 64'(out_valid), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/field_splitter_pipe.md
Name: field_splitter_pipe

Overview:
- Parametrised, registered successor to the combinational word splitter in the core datapath.
- Accepts a DATA_W-bit word over a valid/ready handshake and extracts three fields:
  - an immediate field (zero- or sign-extended to DATA_W),
  - an opcode-style field,
  - a single flag bit.
- Decouples fetch from decode through a 2-entry skid buffer and counts delivered words.

Parameters:
- DATA_W, 32, input word width.
- IMM_W, 16, immediate field width; 1..DATA_W.
- IMM_LSB, 0, immediate field LSB position; IMM_LSB+IMM_W <= DATA_W.
- OP_W, 8, opcode field width; 1..DATA_W.
- OP_LSB, 16, opcode field LSB position; OP_LSB+OP_W <= DATA_W.
- FLAG_BIT, 24, bit index of the flag; < DATA_W.
- CNT_W, 8, width of the delivered-word counter.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous clear of both buffer entries.
- in_word, input, DATA_W, word to split.
- in_sext, input, 1, per-word mode: 1 = sign-extend imm, 0 = zero-extend; captured with the word.
- in_valid, input, 1, in_word/in_sext valid.
- in_ready, output, 1, block can accept this cycle.
- imm_out, output, DATA_W, extended immediate.
- op_out, output, OP_W, in_word[OP_LSB+OP_W-1:OP_LSB].
- flag_out, output, 1, in_word[FLAG_BIT].
- out_valid, output, 1, output fields valid.
- out_ready, input, 1, downstream accepts.
- word_cnt, output, CNT_W, number of output transfers, mod 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, in_ready=1, imm_out=0, op_out=0, flag_out=0, word_cnt=0.
  - Skid entry is empty.
  - Reset asserted mid-transfer discards both entries; nothing is replayed.
- Field extraction and extension:
  - Fields are extracted and extended at input acceptance; buffers store the extracted fields, not the raw word.
  - sext=1: imm_out = {DATA_W-IMM_W copies of in_word[IMM_LSB+IMM_W-1], field}.
  - sext=0: upper bits are zero.
  - IMM_W == DATA_W: no extension.
- Handshake:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Outputs hold stable while out_valid=1 and out_ready=0.
- Storage: output register (OUT) plus one skid register (SKID).
  - in_ready is registered and equals !SKID_full.
- State transitions per cycle (flush=0):
  - OUT empty, or output transfer this cycle, with SKID empty: an input transfer loads OUT. Latency is 1 cycle, so out_valid rises the cycle after acceptance.
  - OUT full, no output transfer: an input transfer loads SKID; in_ready drops next cycle.
  - Output transfer with SKID full: SKID moves to OUT, SKID empties, in_ready rises next cycle. No input is accepted that cycle because in_ready=0.
  - Output transfer, SKID empty, no input transfer: out_valid falls next cycle.
  - Simultaneous input and output transfer with SKID empty: new word goes to OUT; out_valid stays 1; throughput is 1 word/cycle.
- Ordering: words are delivered strictly in acceptance order; none dropped or duplicated.
- flush:
  - Next cycle out_valid=0, SKID empty, in_ready=1.
  - Flush has priority over a coincident input transfer; that word is discarded even though in_ready was 1.
  - An output transfer in the flush cycle still counts.
  - Output data registers keep their stale values.
- word_cnt:
  - Increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
  - Not affected by flush; cleared only by reset.
- Parameter violations are caught by elaboration-time checks (generate an error).

Test Plan:
- Reset release, then in_word=0x01AB8001, in_sext=1, out_ready=1 -> next cycle out_valid=1, imm_out=0xFFFF8001, op_out=0xAB, flag_out=1; word_cnt=1 after the transfer.
- Same word with in_sext=0 -> imm_out=0x00008001. Then in_word=0x00CD7FFF, in_sext=1 -> imm_out=0x00007FFF, op_out=0xCD, flag_out=0.
- Streaming with out_ready=0 -> two words accepted, in_ready=0 from the cycle after the second. Raise out_ready -> both delivered in order, in_ready back to 1; a third word is then accepted.
- Continuous in_valid=1 and out_ready=1 for 300 words -> one word per cycle, no bubbles, word_cnt wraps to 300 mod 256 = 44.
- Buffer full, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input not delivered, word_cnt unchanged.
- Drop rst_n asynchronously mid-stream, between clock edges -> out_valid and word_cnt go to 0 immediately; in_ready=1 after release.
